// File: rtl/uart_rx_oversampled_if.sv
// rtl/uart_rx_oversampled_if.sv - serial line, tick and received-word bundle for the UART receiver
`timescale 1ns/1ps

interface uart_rx_oversampled_if #(
    parameter int DATA_BITS = 8
);
    logic                 sample_tick;
    logic                 rx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 parity_err;
    logic                 busy;

    modport master (
        output sample_tick,
        output rx,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  parity_err,
        input  busy
    );

    modport slave (
        input  sample_tick,
        input  rx,
        output rx_data,
        output rx_valid,
        output frame_err,
        output parity_err,
        output busy
    );
endinterface

// File: rtl/uart_rx_oversampled.sv
// rtl/uart_rx_oversampled.sv - oversampled UART receive deframer with parity and stop-bit checks
`timescale 1ns/1ps

module uart_rx_oversampled #(
    parameter int DATA_BITS    = 8,
    parameter int OVERSAMPLING = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic                  clock,
    input  logic                  nreset,
    uart_rx_oversampled_if.slave  bus
);

    localparam int CW    = $clog2(OVERSAMPLING);
    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0]    HALF_M1  = CW'(OVERSAMPLING / 2 - 1);
    localparam logic [CW-1:0]    FULL_M1  = CW'(OVERSAMPLING - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);
    localparam logic             ODD_BIT  = (PARITY_ODD != 0);
    localparam logic             HAS_PAR  = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

    state_t               state;
    logic                 rx_meta;
    logic                 rx_s;
    logic [CW-1:0]        tick_cnt;
    logic [BIT_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 perr;
    logic                 stop_s;
    logic                 deliver;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 frame_err_q;
    logic                 parity_err_q;
    logic                 busy_q;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            rx_meta      <= 1'b1;
            rx_s         <= 1'b1;
            state        <= IDLE;
            tick_cnt     <= '0;
            bit_idx      <= '0;
            shift        <= '0;
            perr         <= 1'b0;
            stop_s       <= 1'b0;
            deliver      <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            rx_meta    <= bus.rx;
            rx_s       <= rx_meta;
            rx_valid_q <= 1'b0;
            deliver    <= 1'b0;

            // Publish the frame one clock after the stop-bit sample, independent of ticks
            if (deliver) begin
                rx_data_q    <= shift;
                frame_err_q  <= ~stop_s;
                parity_err_q <= perr;
                rx_valid_q   <= 1'b1;
            end

            if (bus.sample_tick) begin
                unique case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            state    <= START;
                            tick_cnt <= '0;
                            busy_q   <= 1'b1;
                        end
                    end

                    START: begin
                        if (tick_cnt == HALF_M1) begin
                            if (rx_s) begin
                                state  <= IDLE;
                                busy_q <= 1'b0;
                            end else begin
                                state    <= DATA;
                                tick_cnt <= '0;
                                bit_idx  <= '0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end

                    DATA: begin
                        if (tick_cnt == FULL_M1) begin
                            shift[bit_idx] <= rx_s;
                            tick_cnt       <= '0;
                            if (bit_idx == LAST_BIT) begin
                                state <= HAS_PAR ? PARITY : STOP;
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end

                    PARITY: begin
                        if (tick_cnt == FULL_M1) begin
                            perr     <= (^shift) ^ rx_s ^ ODD_BIT;
                            tick_cnt <= '0;
                            state    <= STOP;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end

                    STOP: begin
                        if (tick_cnt == FULL_M1) begin
                            stop_s   <= rx_s;
                            deliver  <= 1'b1;
                            tick_cnt <= '0;
                            if (rx_s) begin
                                state  <= IDLE;
                                busy_q <= 1'b0;
                            end else begin
                                state <= BREAK;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end

                    BREAK: begin
                        // A line held low must return high before another start can be seen
                        if (rx_s) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end

                    default: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.rx_data    = rx_data_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.parity_err = parity_err_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb/tb_uart_rx_oversampled.sv - randomized frame stimulus against a queue-based expected-word model
`timescale 1ns/1ps

module tb_uart_rx_oversampled;

    localparam int OS = 8;

    logic clock  = 1'b0;
    logic nreset = 1'b0;
    logic tick   = 1'b1;
    logic rx0    = 1'b1;
    logic rx1    = 1'b1;
    int   tick_mode = 0;
    int   cyc = 0;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected entries are {parity_err, frame_err, data}
    logic [9:0] expq [2][$];
    logic [9:0] hold [2];
    int         vcount [2];
    int         last_valid_cyc [2];

    uart_rx_oversampled_if #(.DATA_BITS(8)) u0 ();
    uart_rx_oversampled_if #(.DATA_BITS(8)) u1 ();

    assign u0.sample_tick = tick;
    assign u1.sample_tick = tick;
    assign u0.rx          = rx0;
    assign u1.rx          = rx1;

    uart_rx_oversampled #(
        .DATA_BITS(8), .OVERSAMPLING(OS), .PARITY_EN(0), .PARITY_ODD(0)
    ) dut0 (
        .clock(clock), .nreset(nreset), .bus(u0.slave)
    );

    uart_rx_oversampled #(
        .DATA_BITS(8), .OVERSAMPLING(OS), .PARITY_EN(1), .PARITY_ODD(0)
    ) dut1 (
        .clock(clock), .nreset(nreset), .bus(u1.slave)
    );

    always #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        cyc = cyc + 1;
    end

    initial forever begin
        @(posedge clock);
        #1;
        tick = (tick_mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h", name, k, act, exp);
        end
    endtask

    // Every cycle: outputs must equal the last expected word; a valid must consume one expected word
    initial forever begin
        logic       v, fe, pe, bz;
        logic [7:0] d;
        @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            v  = (k == 0) ? u0.rx_valid   : u1.rx_valid;
            d  = (k == 0) ? u0.rx_data    : u1.rx_data;
            fe = (k == 0) ? u0.frame_err  : u1.frame_err;
            pe = (k == 0) ? u0.parity_err : u1.parity_err;
            bz = (k == 0) ? u0.busy       : u1.busy;
            if (!nreset) begin
                hold[k] = '0;
                chk("reset_outputs", k, {v, bz, fe, pe, d}, 32'h0);
            end else begin
                if (v) begin
                    vcount[k]++;
                    last_valid_cyc[k] = cyc;
                    if (expq[k].size() == 0) chk("unexpected_rx_valid", k, 32'h1, 32'h0);
                    else hold[k] = expq[k].pop_front();
                end
                chk("rx_data", k, {24'h0, d}, {24'h0, hold[k][7:0]});
                chk("frame_err", k, {31'h0, fe}, {31'h0, hold[k][8]});
                chk("parity_err", k, {31'h0, pe}, {31'h0, hold[k][9]});
            end
        end
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            int g;
            g = 0;
            do begin
                @(posedge clock);
                g++;
            end while (!tick && g < 64);
            if (!tick) chk("tick_timeout", 0, 32'h1, 32'h0);
        end
        #1;
    endtask

    task automatic drive(input int k, input logic b);
        if (k == 0) rx0 = b;
        else        rx1 = b;
    endtask

    task automatic send_frame(input int k, input logic [7:0] d, input logic par,
                              input logic stop, input int gap);
        logic perr;
        perr = (k == 1) ? ((($countones(d) + int'(par)) % 2) != 0) : 1'b0;
        expq[k].push_back({perr, ~stop, d});
        drive(k, 1'b0);
        wait_ticks(OS);
        for (int i = 0; i < 8; i++) begin
            drive(k, d[i]);
            wait_ticks(OS);
        end
        if (k == 1) begin
            drive(k, par);
            wait_ticks(OS);
        end
        drive(k, stop);
        wait_ticks(OS);
        for (int i = 0; i < gap; i++) begin
            drive(k, 1'b1);
            wait_ticks(OS);
        end
    endtask

    initial begin
        int t0, vc;
        logic [7:0] pat;

        repeat (3) @(negedge clock);
        chk("reset_busy", 0, {31'h0, u0.busy}, 32'h0);
        chk("reset_valid", 1, {31'h0, u1.rx_valid}, 32'h0);
        #2 nreset = 1'b1;
        wait_ticks(16);

        // Single 0x55 8N1 frame with exact latency
        vc = vcount[0];
        t0 = cyc;
        send_frame(0, 8'h55, 1'b0, 1'b1, 0);
        repeat (3) @(negedge clock);
        chk("t1_valid_count", 0, vcount[0] - vc, 1);
        chk("t1_latency", 0, last_valid_cyc[0] - t0, 80);
        chk("t1_rx_data", 0, {24'h0, u0.rx_data}, 32'h55);
        chk("t1_errs", 0, {30'h0, u0.frame_err, u0.parity_err}, 32'h0);
        wait_ticks(16);

        // False start: low for two ticks only
        vc = vcount[0];
        drive(0, 1'b0);
        wait_ticks(2);
        drive(0, 1'b1);
        repeat (2) @(negedge clock);
        chk("t2_busy_in_start", 0, {31'h0, u0.busy}, 32'h1);
        wait_ticks(4);
        chk("t2_busy_dropped", 0, {31'h0, u0.busy}, 32'h0);
        wait_ticks(16);
        chk("t2_no_valid", 0, vcount[0] - vc, 0);

        // Stop bit low, line held low: one word then break until line recovers
        vc = vcount[0];
        send_frame(0, 8'hA3, 1'b0, 1'b0, 0);
        drive(0, 1'b0);
        wait_ticks(40);
        chk("t3_valid_count", 0, vcount[0] - vc, 1);
        chk("t3_rx_data", 0, {24'h0, u0.rx_data}, 32'hA3);
        chk("t3_frame_err", 0, {31'h0, u0.frame_err}, 32'h1);
        chk("t3_busy_break", 0, {31'h0, u0.busy}, 32'h1);
        drive(0, 1'b1);
        wait_ticks(16);
        chk("t3_busy_idle", 0, {31'h0, u0.busy}, 32'h0);
        chk("t3_no_retrigger", 0, vcount[0] - vc, 1);
        send_frame(0, 8'h5A, 1'b0, 1'b1, 2);
        chk("t3_next_frame", 0, vcount[0] - vc, 2);

        // Even parity on 0x07 (three ones): parity bit 0 is wrong, 1 is right
        send_frame(1, 8'h07, 1'b0, 1'b1, 2);
        chk("t4_rx_data", 1, {24'h0, u1.rx_data}, 32'h07);
        chk("t4_parity_bad", 1, {31'h0, u1.parity_err}, 32'h1);
        send_frame(1, 8'h07, 1'b1, 1'b1, 2);
        chk("t4_parity_good", 1, {31'h0, u1.parity_err}, 32'h0);

        // Back-to-back frames without an idle gap
        vc = vcount[0];
        send_frame(0, 8'h00, 1'b0, 1'b1, 0);
        send_frame(0, 8'hFF, 1'b0, 1'b1, 0);
        send_frame(0, 8'h81, 1'b0, 1'b1, 2);
        chk("t5_valid_count", 0, vcount[0] - vc, 3);
        chk("t5_last_word", 0, {24'h0, u0.rx_data}, 32'h81);

        // Reset during bit 4 of 0x3C, then a clean 0xC3
        vc = vcount[0];
        pat = 8'h3C;
        drive(0, 1'b0);
        wait_ticks(OS);
        for (int i = 0; i < 4; i++) begin
            drive(0, pat[i]);
            wait_ticks(OS);
        end
        drive(0, pat[4]);
        wait_ticks(4);
        #2 nreset = 1'b0;
        repeat (3) @(negedge clock);
        chk("t6_rx_data_reset", 0, {24'h0, u0.rx_data}, 32'h0);
        chk("t6_busy_reset", 0, {31'h0, u0.busy}, 32'h0);
        drive(0, 1'b1);
        @(negedge clock);
        #2 nreset = 1'b1;
        wait_ticks(16);
        chk("t6_no_aborted_valid", 0, vcount[0] - vc, 0);
        send_frame(0, 8'hC3, 1'b0, 1'b1, 2);
        chk("t6_valid_count", 0, vcount[0] - vc, 1);
        chk("t6_rx_data", 0, {24'h0, u0.rx_data}, 32'hC3);

        // Randomized frames, tick cadence and error bits on both receivers
        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 15; n++) begin
                logic [7:0] d;
                logic       par, stop;
                int         gap;
                tick_mode = $urandom_range(0, 1);
                d    = 8'($urandom);
                par  = 1'($urandom);
                stop = ($urandom_range(0, 5) != 0);
                gap  = stop ? $urandom_range(0, 2) : $urandom_range(1, 2);
                send_frame(k, d, par, stop, gap);
            end
            tick_mode = 0;
            wait_ticks(24);
        end

        chk("final_busy0", 0, {31'h0, u0.busy}, 32'h0);
        chk("final_busy1", 1, {31'h0, u1.busy}, 32'h0);
        chk("final_queue0_empty", 0, expq[0].size(), 0);
        chk("final_queue1_empty", 1, expq[1].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
